// File: rtl/sram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_port_arbiter_pkg
// Description : Shared definitions for the SRAM port arbiter. This package
//               holds the default address and data widths, the RW pin
//               encoding, and the arbiter state type.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_port_arbiter_pkg;

    localparam int DEF_A_WIDTH = 16;
    localparam int DEF_D_WIDTH = 8;

    // SRAM RW pin encoding
    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

endpackage : sram_port_arbiter_pkg
`default_nettype wire

// File: rtl/sram_port_arbiter_rr_priority_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_pick
// Description : Combinational round-robin picker. It searches Req_i upward
//               from Last_i+1 and wraps modulo N. The first requester it
//               finds is the winner.
// Ports       : Req_i  - request vector
//               Last_i - index of the previous winner
//               Gnt_o  - one-hot winner
//               Idx_o  - binary index of the winner
//               Any_o  - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_pick
    import sram_port_arbiter_pkg::*;
#(
    parameter int N    = 3,
    parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    Req_i,
    input  logic [ID_W-1:0] Last_i,
    output logic [N-1:0]    Gnt_o,
    output logic [ID_W-1:0] Idx_o,
    output logic            Any_o
);

    int w_j;

    // Offsets 1..N visit every requester once. Offset N wraps back to
    // Last_i, so the previous winner has the lowest priority.
    always_comb begin
        Gnt_o = '0;
        Idx_o = '0;
        Any_o = 1'b0;
        w_j   = 0;
        for (int k = 1; k <= N; k++) begin
            w_j = (int'(Last_i) + k) % N;
            if (!Any_o && Req_i[w_j]) begin
                Any_o      = 1'b1;
                Gnt_o[w_j] = 1'b1;
                Idx_o      = ID_W'(w_j);
            end
        end
    end

endmodule : rr_priority_pick
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_port_arbiter
// Description : Round-robin arbiter that shares one registered-output SRAM
//               between N_REQ requesters. Arbitration takes zero cycles.
//               Read data returns one cycle after the grant. A per-requester
//               Lock gives the owner exclusive back-to-back access.
// Ports       : Clk, Rst            - clock, async active-high reset
//               Req/Rw/Lock         - per-requester request, direction, lock
//               Addr/WData          - packed per-requester address/data
//               Gnt                 - one-hot access issued this cycle
//               RValid/RData        - one-hot read return and shared data
//               Mem_Addr/Mem_Out    - SRAM Addr / Data_In
//               Mem_In              - SRAM Data_Out (registered in the SRAM)
//               Mem_En/Mem_Rw       - SRAM En / RW
// Revision    : 1.0 - initial release
// ============================================================================
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int A_WIDTH = DEF_A_WIDTH,
    parameter int D_WIDTH = DEF_D_WIDTH,
    parameter int N_REQ   = 3
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic [N_REQ-1:0]           Req,
    input  logic [N_REQ-1:0]           Rw,
    input  logic [N_REQ-1:0]           Lock,
    input  logic [N_REQ*A_WIDTH-1:0]   Addr,
    input  logic [N_REQ*D_WIDTH-1:0]   WData,
    output logic [N_REQ-1:0]           Gnt,
    output logic [N_REQ-1:0]           RValid,
    output logic [D_WIDTH-1:0]         RData,
    output logic [A_WIDTH-1:0]         Mem_Addr,
    output logic [D_WIDTH-1:0]         Mem_Out,
    input  logic [D_WIDTH-1:0]         Mem_In,
    output logic                       Mem_En,
    output logic                       Mem_Rw
);

    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e              state_q,   state_d;
    logic [ID_W-1:0]     last_q,    last_d;
    logic [ID_W-1:0]     owner_q,   owner_d;
    logic                pend_q,    pend_d;
    logic [ID_W-1:0]     pend_id_q, pend_id_d;
    logic [A_WIDTH-1:0]  addr_q;
    logic [D_WIDTH-1:0]  wdata_q;

    logic [N_REQ-1:0]    w_pick_gnt;
    logic [ID_W-1:0]     w_pick_idx;
    logic                w_pick_any;
    logic                w_grant;
    logic [ID_W-1:0]     w_sel;
    logic [N_REQ-1:0]    w_gnt_vec;

    rr_priority_pick #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_pick (
        .Req_i  (Req),
        .Last_i (last_q),
        .Gnt_o  (w_pick_gnt),
        .Idx_o  (w_pick_idx),
        .Any_o  (w_pick_any)
    );

    // Next-state and grant decode
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        pend_d    = 1'b0;
        pend_id_d = pend_id_q;
        w_grant   = 1'b0;
        w_sel     = owner_q;
        w_gnt_vec = '0;

        case (state_q)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_grant   = 1'b1;
                    w_sel     = w_pick_idx;
                    w_gnt_vec = w_pick_gnt;
                end
            end
            ST_LOCKED: begin
                if (Req[owner_q]) begin
                    w_grant   = 1'b1;
                    w_sel     = owner_q;
                    w_gnt_vec = N_REQ'(1) << owner_q;
                end
                // Leaving the lock does not depend on whether the owner is
                // granted. A grant in this cycle still goes ahead.
                if (!Lock[owner_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // No access is issued while reset is held. This keeps every output
        // at zero during an asynchronous reset.
        if (Rst) begin
            w_grant   = 1'b0;
            w_gnt_vec = '0;
        end

        if (w_grant) begin
            last_d = w_sel;
            if (Rw[w_sel] == RW_READ) begin
                pend_d    = 1'b1;
                pend_id_d = w_sel;
            end
            if (state_q == ST_IDLE && Lock[w_sel]) begin
                state_d = ST_LOCKED;
                owner_d = w_sel;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= ST_IDLE;
            last_q    <= ID_W'(N_REQ - 1);
            owner_q   <= '0;
            pend_q    <= 1'b0;
            pend_id_q <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            pend_q    <= pend_d;
            pend_id_q <= pend_id_d;
            addr_q    <= Mem_Addr;
            wdata_q   <= Mem_Out;
        end
    end

    // Memory-side outputs. Address and data hold their last issued value
    // between accesses.
    assign Gnt      = w_gnt_vec;
    assign Mem_En   = w_grant;
    assign Mem_Rw   = w_grant & Rw[w_sel];
    assign Mem_Addr = w_grant ? Addr[w_sel*A_WIDTH +: A_WIDTH]  : addr_q;
    assign Mem_Out  = w_grant ? WData[w_sel*D_WIDTH +: D_WIDTH] : wdata_q;

    // The SRAM registers its output, so the data for a read granted in the
    // previous cycle is already on Mem_In.
    assign RValid   = pend_q ? (N_REQ'(1) << pend_id_q) : '0;
    assign RData    = pend_q ? Mem_In : '0;

endmodule : sram_port_arbiter
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_port_arbiter
// Description : Self-checking bench for sram_port_arbiter. It includes a
//               registered-output SRAM model and a read-return scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_port_arbiter;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [2:0]  Req = '0, Rw = '0, Lock = '0;
    logic [47:0] Addr = '0;
    logic [23:0] WData = '0;
    logic [2:0]  Gnt, RValid;
    logic [7:0]  RData, Mem_Out, Mem_In;
    logic [15:0] Mem_Addr;
    logic        Mem_En, Mem_Rw;

    sram_port_arbiter #(.A_WIDTH(16), .D_WIDTH(8), .N_REQ(3)) dut (
        .Clk(Clk), .Rst(Rst), .Req(Req), .Rw(Rw), .Lock(Lock),
        .Addr(Addr), .WData(WData), .Gnt(Gnt), .RValid(RValid),
        .RData(RData), .Mem_Addr(Mem_Addr), .Mem_Out(Mem_Out),
        .Mem_In(Mem_In), .Mem_En(Mem_En), .Mem_Rw(Mem_Rw)
    );

    always #5 Clk = ~Clk;

    // SRAM model with a preload port and a registered read output
    logic [7:0]  sram [0:65535];
    logic [7:0]  mem_dout = '0;
    logic        pl_we = 1'b0;
    logic [15:0] pl_addr = '0;
    logic [7:0]  pl_data = '0;
    assign Mem_In = mem_dout;

    always @(posedge Clk) begin
        if (pl_we) sram[pl_addr] <= pl_data;
        else if (Mem_En) begin
            if (Mem_Rw) sram[Mem_Addr] <= Mem_Out;
            else        mem_dout <= sram[Mem_Addr];
        end
    end

    // Reference memory and read-return scoreboard
    logic [7:0] ref_mem [0:65535];
    typedef struct {
        logic [2:0] id_vec;
        logic [7:0] data;
    } rd_exp_t;
    rd_exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle. The task drives inputs at the falling edge, checks the
    // return of the previous read and this cycle's grant, then records the
    // expected effect of the access.
    task automatic step(input logic [2:0] req, input logic [2:0] rw, input logic [2:0] lock,
                        input logic [47:0] addr, input logic [23:0] wdata,
                        input logic [2:0] exp_gnt, input string tag);
        rd_exp_t     e;
        int          w;
        logic [15:0] a;
        logic [7:0]  d;
        @(negedge Clk);
        Req = req; Rw = rw; Lock = lock; Addr = addr; WData = wdata;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, ".rvalid"}, 32'(RValid), 32'(e.id_vec));
            chk({tag, ".rdata"}, 32'(RData), 32'(e.data));
        end else begin
            chk({tag, ".no_rvalid"}, 32'(RValid), 32'd0);
        end
        chk({tag, ".gnt"}, 32'(Gnt), 32'(exp_gnt));
        w = -1;
        for (int i = 0; i < 3; i++) if (exp_gnt[i]) w = i;
        chk({tag, ".en"}, 32'(Mem_En), (w >= 0) ? 32'd1 : 32'd0);
        if (w >= 0) begin
            a = addr[w*16 +: 16];
            d = wdata[w*8 +: 8];
            chk({tag, ".mem_rw"}, 32'(Mem_Rw), 32'(rw[w]));
            chk({tag, ".mem_addr"}, 32'(Mem_Addr), 32'(a));
            if (rw[w]) begin
                chk({tag, ".mem_out"}, 32'(Mem_Out), 32'(d));
                ref_mem[a] = d;
            end else begin
                e.id_vec = 3'b001 << w;
                e.data   = ref_mem[a];
                sb.push_back(e);
            end
        end else begin
            chk({tag, ".mem_rw_idle"}, 32'(Mem_Rw), 32'd0);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        @(negedge Clk);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        ref_mem[a] = d;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".gnt"},      32'(Gnt),      32'd0);
        chk({tag, ".rvalid"},   32'(RValid),   32'd0);
        chk({tag, ".rdata"},    32'(RData),    32'd0);
        chk({tag, ".mem_en"},   32'(Mem_En),   32'd0);
        chk({tag, ".mem_rw"},   32'(Mem_Rw),   32'd0);
        chk({tag, ".mem_addr"}, 32'(Mem_Addr), 32'd0);
        chk({tag, ".mem_out"},  32'(Mem_Out),  32'd0);
    endtask

    localparam logic [47:0] A_STD = {16'h0010, 16'h0002, 16'h0001};
    localparam logic [47:0] A_RMW = {16'h0010, 16'h0002, 16'h0100};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state and preload
        #2;
        check_all_zero("reset");
        preload(16'h0010, 8'hA5);
        preload(16'h0100, 8'h41);
        preload(16'h0001, 8'h11);
        preload(16'h0002, 8'h22);
        @(negedge Clk);
        pl_we = 1'b0;
        Rst   = 1'b0;

        // Single read by requester 1
        step(3'b010, 3'b000, 3'b000, A_STD, 24'h0, 3'b010, "rd1");
        step(3'b000, 3'b000, 3'b000, A_STD, 24'h0, 3'b000, "rd1_ret");

        // Fairness with all requesting. Last=1, so the rotation starts at 2.
        for (int i = 0; i < 6; i++)
            step(3'b111, 3'b000, 3'b000, A_STD, 24'h0, 3'b001 << ((2 + i) % 3), "rr");

        // Requester 2 writes the top address, then reads it back
        step(3'b100, 3'b100, 3'b000, {16'hFFFF, 32'h0}, {8'h3C, 16'h0}, 3'b100, "wr_top");
        step(3'b100, 3'b000, 3'b000, {16'hFFFF, 32'h0}, 24'h0, 3'b100, "rd_top");
        step(3'b000, 3'b000, 3'b000, A_STD, 24'h0, 3'b000, "rd_top_ret");

        // Locked read-modify-write by requester 0 while 1 and 2 request
        step(3'b111, 3'b000, 3'b001, A_RMW, 24'h0, 3'b001, "rmw_rd");
        step(3'b111, 3'b001, 3'b000, A_RMW, 24'h000042, 3'b001, "rmw_wr");
        step(3'b110, 3'b000, 3'b000, A_RMW, 24'h0, 3'b010, "after_rmw");
        step(3'b001, 3'b000, 3'b000, A_RMW, 24'h0, 3'b001, "rmw_verify");

        // The lock is held while the owner is idle. A release gives no
        // grant in its own cycle.
        step(3'b001, 3'b000, 3'b001, A_STD, 24'h0, 3'b001, "lk_rd");
        step(3'b110, 3'b000, 3'b001, A_STD, 24'h0, 3'b000, "lk_idle");
        step(3'b110, 3'b000, 3'b000, A_STD, 24'h0, 3'b000, "lk_rel");
        step(3'b110, 3'b000, 3'b000, A_STD, 24'h0, 3'b010, "lk_after");
        step(3'b000, 3'b000, 3'b000, A_STD, 24'h0, 3'b000, "lk_ret");

        // Asynchronous reset between a read grant and its return
        step(3'b001, 3'b000, 3'b000, A_STD, 24'h0, 3'b001, "rst_rd");
        @(posedge Clk);
        #2;
        Rst = 1'b1;
        Req = 3'b000;
        #1;
        check_all_zero("mid_reset");
        sb.delete();
        @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        step(3'b111, 3'b000, 3'b000, A_STD, 24'h0, 3'b001, "post_rst");
        step(3'b000, 3'b000, 3'b000, A_STD, 24'h0, 3'b000, "post_rst_ret");

        // Back-to-back reads from different requesters
        step(3'b001, 3'b000, 3'b000, A_STD, 24'h0, 3'b001, "b2b_0");
        step(3'b010, 3'b000, 3'b000, A_STD, 24'h0, 3'b010, "b2b_1");
        step(3'b000, 3'b000, 3'b000, A_STD, 24'h0, 3'b000, "b2b_ret");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_sram_port_arbiter
`default_nettype wire
